seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//  Parametrised serial pattern detector; successor to the fixed 3-FF "1111" detector.
//  Matches any N-bit pattern on a 1-bit serial input.
//  Overlapping or non-overlapping detection is selectable.
//  Adds a bit-enable qualifier and a saturating match counter with sticky saturation flag.
//  Sits after serial receive logic; out drives event/interrupt logic, match_cnt feeds status.
// PARAMETERS
//  N        4        pattern length in bits, N >= 2
//  PATTERN  4'b1111  N-bit target; MSB = first bit received, LSB = last bit received
//  OVERLAP  1        1: overlapping matches allowed; 0: bits of a match are consumed
//  CNT_W    8        width of match_cnt, CNT_W >= 1
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-low reset (0 = reset)
//  en         in   1      1: x is a valid bit this cycle; 0: no bit, history frozen
//  x          in   1      serial data bit, sampled on the rising clk edge when en=1
//  clr_cnt    in   1      synchronous clear of match_cnt and cnt_sat
//  out        out  1      registered single-cycle match pulse
//  match_cnt  out  CNT_W  number of matches since reset or clear, saturating
//  cnt_sat    out  1      sticky; set when match_cnt saturates
// BEHAVIOUR
//  Reset (rst=0, async): hist=0, fill=0, out=0, match_cnt=0, cnt_sat=0.
//   All outputs stay at these values while rst=0.
//  State held:
//   - hist[N-2:0]: the last N-1 accepted bits.
//   - fill: count of accepted bits, saturating at N-1.
//  Accepting a bit (edge with en=1):
//   - cand = {hist, x}
//   - hit = (fill == N-1) && (cand == PATTERN)
//   - A pattern is never reported before N bits have been accepted. A zero pattern does not
//     false-fire after reset.
//  Edge with en=1, hit=1:
//   - out <= 1
//   - OVERLAP=1: hist <= cand[N-2:0]
//   - OVERLAP=0: hist <= 0 and fill <= 0; the next match needs N fresh bits.
//  Edge with en=1, hit=0: hist <= cand[N-2:0]; fill increments and saturates at N-1; out <= 0.
//  Edge with en=0: hist and fill hold; out <= 0. An idle gap is not a data bit.
//  Latency: out is high for exactly the one cycle after the edge that sampled the final
//   pattern bit. Back-to-back overlapping matches give out high on consecutive cycles.
//  Counter, evaluated at the same edge:
//   - clr_cnt=1, hit=0: match_cnt <= 0, cnt_sat <= 0.
//   - clr_cnt=1, hit=1: match_cnt <= 1, cnt_sat <= 0 (clear first, then count).
//   - clr_cnt=0, hit=1, match_cnt < 2^CNT_W-1: increment.
//   - clr_cnt=0, hit=1, match_cnt = 2^CNT_W-1: hold the value and set cnt_sat <= 1; no wrap.
//   - cnt_sat clears only on clr_cnt or reset.
//  Reset mid-stream: history and fill are discarded. Bits received before reset never
//   contribute to a match. A pending out pulse is forced low immediately.
//  x is don't-care when en=0. clr_cnt does not affect hist, fill or out.
// TESTING  (N=4 unless stated; x listed in arrival order, en=1 unless stated)
//  1. PATTERN=1111, OVERLAP=1, x=1111111 (7 ones)
//     -> out pulses after bits 4, 5, 6 and 7 (4 consecutive cycles); match_cnt=4.
//  2. PATTERN=1111, OVERLAP=0, x=11111111 (8 ones)
//     -> out pulses after bits 4 and 8 only; match_cnt=2.
//  3. PATTERN=1011, OVERLAP=1, x=1011011
//     -> pulses after bits 4 and 7.
//     Same stream with OVERLAP=0 -> pulse after bit 4 only.
//  4. PATTERN=1111, x=1,1,(en=0,x=0),1,1
//     -> one pulse after the 4th accepted bit. Then x=1,1,1, rst low 1 cycle, x=1
//     -> no pulse, out=0 during reset.
//  5. PATTERN=0000, x=0,0,0 straight after reset -> no pulse; 4th 0 -> pulse.
//  6. CNT_W=2, PATTERN=1111, OVERLAP=1, 8 ones -> match_cnt=3, cnt_sat=1.
//     clr_cnt asserted on a hitting edge -> match_cnt=1, cnt_sat=0.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: N-bit serial pattern detector with enable, overlap select and saturating match counter
module seq_detect_param #(
  parameter int N = 4,
  parameter logic [N-1:0] PATTERN = 4'b1111,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  localparam int FW = $clog2(N);
  localparam logic [FW-1:0] FULL = FW'(N - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [N-2:0] hist;
  logic [FW-1:0] fill;
  logic [N-1:0] cand;
  logic hit;
  always_comb begin
    cand = {hist, x};
    hit = en && (fill == FULL) && (cand == PATTERN);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
      out <= 1'b0;
      match_cnt <= '0;
      cnt_sat <= 1'b0;
    end else begin
      out <= hit;
      // a non-overlapping hit consumes its bits, so the next match needs N fresh ones
      if (en) begin
        hist <= (hit && !OVERLAP) ? '0 : cand[N-2:0];
        fill <= (hit && !OVERLAP) ? '0 : (fill == FULL) ? FULL : fill + 1'b1;
      end
      if (clr_cnt) begin
        match_cnt <= hit ? CNT_W'(1) : '0;
        cnt_sat <= 1'b0;
      end else if (hit) begin
        match_cnt <= (match_cnt == CMAX) ? CMAX : match_cnt + 1'b1;
        cnt_sat <= cnt_sat | (match_cnt == CMAX);
      end
    end
  end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: randomized check of three detector configurations against a behavioural model
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic x = 1'b0;
  logic clr_cnt = 1'b0;
  logic out0, out1, out2;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [2:0] cnt2;
  logic sat0, sat1, sat2;
  int checks = 0;
  int errors = 0;
  logic [3:0] pat [3];
  bit ov [3];
  int cmax [3];
  logic [31:0] sh [3];
  int nacc [3];
  int mcnt [3];
  bit msat [3];
  bit mout [3];

  always #5 clk = ~clk;

  seq_detect_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
    .out(out0), .match_cnt(cnt0), .cnt_sat(sat0));
  seq_detect_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
    .out(out1), .match_cnt(cnt1), .cnt_sat(sat1));
  seq_detect_param #(.N(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr_cnt(clr_cnt),
    .out(out2), .match_cnt(cnt2), .cnt_sat(sat2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      sh[k] = '0;
      nacc[k] = 0;
      mcnt[k] = 0;
      msat[k] = 1'b0;
      mout[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [31:0] go [3];
    logic [31:0] gc [3];
    logic [31:0] gs [3];
    go[0] = 32'(out0); go[1] = 32'(out1); go[2] = 32'(out2);
    gc[0] = 32'(cnt0); gc[1] = 32'(cnt1); gc[2] = 32'(cnt2);
    gs[0] = 32'(sat0); gs[1] = 32'(sat1); gs[2] = 32'(sat2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("out%0d", k), go[k], 32'(mout[k]));
      check($sformatf("cnt%0d", k), gc[k], 32'(mcnt[k]));
      check($sformatf("sat%0d", k), gs[k], 32'(msat[k]));
    end
  endtask

  task automatic step(input bit e, input bit b, input bit c);
    bit hit;
    en = e;
    x = b;
    clr_cnt = c;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      hit = 1'b0;
      if (e) begin
        sh[k] = {sh[k][30:0], b};
        if (nacc[k] < 4) nacc[k]++;
        hit = (nacc[k] == 4) && (sh[k][3:0] == pat[k]);
        if (hit && !ov[k]) nacc[k] = 0;
      end
      mout[k] = hit;
      if (c) begin
        mcnt[k] = hit ? 1 : 0;
        msat[k] = 1'b0;
      end else if (hit) begin
        if (mcnt[k] == cmax[k]) msat[k] = 1'b1;
        else mcnt[k]++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
  endtask

  initial begin
    pat[0] = 4'b1111; pat[1] = 4'b1011; pat[2] = 4'b0000;
    ov[0] = 1'b1; ov[1] = 1'b0; ov[2] = 1'b1;
    cmax[0] = 255; cmax[1] = 3; cmax[2] = 7;
    model_reset();
    @(negedge clk);
    do_reset();
    feed(32'h7f, 7);
    check("spec1_cnt", 32'(cnt0), 32'd4);
    do_reset();
    feed(32'h5b, 7);
    check("spec3_cnt_nonoverlap", 32'(cnt1), 32'd1);
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("spec4_gap_pulse", 32'(out0), 32'd1);
    do_reset();
    feed(32'h0, 3);
    check("spec5_no_early", 32'(out2), 32'd0);
    feed(32'h0, 1);
    check("spec5_pulse", 32'(out2), 32'd1);
    do_reset();
    feed(32'hf, 4);
    rst = 1'b0;
    #1;
    check("async_rst_out", 32'(out0), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    feed(32'h7, 3);
    do_reset();
    feed(32'h1, 1);
    check("rst_discards_hist", 32'(out0), 32'd0);
    do_reset();
    feed(32'hff, 8);
    check("sat_hold_cnt", 32'(cnt1), 32'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
    check("sat_flag2", 32'(sat2), 32'd1);
    check("sat_cnt2", 32'(cnt2), 32'd7);
    step(1'b1, 1'b0, 1'b1);
    check("clr_on_hit", 32'(cnt2), 32'd1);
    for (int i = 0; i < 3000; i++) begin
      bit ones;
      ones = ((i / 200) % 2) == 0;
      if ($urandom_range(199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(3) != 0,
             ones ? ($urandom_range(4) != 0) : ($urandom_range(4) == 0),
             $urandom_range(31) == 0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
